// File: rtl/adder_pkg.sv
// Shared state encodings and operation codes for the chunked serial adder.
package adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice: {cout, s} = x + y + cin.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_serial_chunked.sv
// Multi-cycle WIDTH-bit add/subtract unit: one CHUNK-bit slice per cycle, LSB first,
// with a registered carry and valid/ready handshakes on both sides.
module adder_serial_chunked
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || NUM_CHUNKS < 1) begin : g_bad_params
      $error("adder_serial_chunked: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg, carry_out_reg, ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_c;
  logic             last_chunk;

  assign chunk_x    = a_reg[int'(idx_reg) * CHUNK +: CHUNK];
  assign chunk_y    = b_reg[int'(idx_reg) * CHUNK +: CHUNK];
  assign last_chunk = (idx_reg == LAST_IDX);

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (chunk_x),
    .y    (chunk_y),
    .cin  (carry_reg),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid)                state_next = S_CALC;
      S_CALC:  if (last_chunk)              state_next = S_DONE;
      S_DONE:  if (out_ready)               state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
  end

  // Subtraction is a + ~b + ~borrow_in, so the operand inversion and carry seed happen at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      idx_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= (op_sub == OP_SUB) ? ~b : b;
            carry_reg <= (op_sub == OP_SUB) ? ~cin : cin;
            idx_reg   <= '0;
          end
        end
        S_CALC: begin
          sum_reg[int'(idx_reg) * CHUNK +: CHUNK] <= chunk_s;
          carry_reg <= chunk_c;
          if (last_chunk) begin
            carry_out_reg <= chunk_c;
            ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (chunk_s[CHUNK-1] != a_reg[WIDTH-1]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_reg;
  assign carry    = carry_out_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_adder_serial_chunked.sv
// Randomized and directed checks of adder_serial_chunked against an arithmetic reference
// model, for WIDTH=16/CHUNK=4 and WIDTH=8/CHUNK=8.
module tb_adder_serial_chunked;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 0, ir16, ov16, or16 = 0, cin16 = 0, op16 = 0, c16, of16;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic        iv8 = 0, ir8, ov8, or8 = 0, cin8 = 0, op8 = 0, c8, of8;
  logic [7:0]  a8 = 0, b8 = 0, sum8;

  adder_serial_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .op_sub(op16), .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .carry(c16), .overflow(of16)
  );

  adder_serial_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .op_sub(op8), .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .carry(c8), .overflow(of8)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; packs {overflow, carry, sum}.
  function automatic logic [17:0] golden(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input bit ci, input bit op);
    longint m, half, ua, ub, t, sa, sb, r;
    bit c, ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    if (!op) begin
      t = ua + ub + longint'(ci);
      c = (t > m);
    end else begin
      t = ua - ub - longint'(ci);
      c = (t >= 0);
    end
    sa = (ua >= half) ? ua - (m + 1) : ua;
    sb = (ub >= half) ? ub - (m + 1) : ub;
    r  = op ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    ov = (r >= half) || (r < -half);
    return {ov, c, 16'(t & m)};
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? ir8 : ir16;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? ov8 : ov16;
  endfunction

  function automatic logic [17:0] res(input bit sel);
    return sel ? {of8, c8, 8'h00, sum8} : {of16, c16, sum16};
  endfunction

  task automatic drive(input bit sel, input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit ci, input bit op);
    if (sel) begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; op8 = op;
    end else begin
      iv16 = v; a16 = a; b16 = b; cin16 = ci; op16 = op;
    end
  endtask

  task automatic set_iv(input bit sel, input bit v);
    if (sel) iv8 = v; else iv16 = v;
  endtask

  task automatic set_or(input bit sel, input bit v);
    if (sel) or8 = v; else or16 = v;
  endtask

  // Waits for in_ready, presents an op for one accepting edge, then scrambles the inputs.
  task automatic start_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input bit ci, input bit op);
    int n = 0;
    while (!rdy(sel) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    drive(sel, 1'b1, a, b, ci, op);
    exp_res = golden(sel ? 8 : 16, a, b, ci, op);
    @(posedge clk); #1;
    drive(sel, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("busy_after_accept", 32'(rdy(sel)), 32'd0);
  endtask

  // Checks latency and result, holds the result under backpressure, then releases it.
  task automatic finish_op(input bit sel, input string tag, input int hold);
    int n = 0;
    while (!vld(sel) && n < 50) begin
      set_or(sel, 1'($urandom));
      @(posedge clk); #1; n++;
    end
    set_or(sel, 1'b0);
    chk({tag, "_latency"}, 32'(n), sel ? 32'd1 : 32'd4);
    chk({tag, "_result"}, 32'(res(sel)), 32'(exp_res));
    chk({tag, "_in_ready_done"}, 32'(rdy(sel)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_result"}, 32'(res(sel)), 32'(exp_res));
      chk({tag, "_hold_valid"}, 32'(vld(sel)), 32'd1);
    end
    set_iv(sel, 1'b0);
    set_or(sel, 1'b1);
    @(posedge clk); #1;
    set_or(sel, 1'b0);
    chk({tag, "_released_valid"}, 32'(vld(sel)), 32'd0);
    chk({tag, "_released_ready"}, 32'(rdy(sel)), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(ir16), 32'd1);
    chk("reset_out_valid", 32'(ov16), 32'd0);
    chk("reset_outputs", 32'({of16, c16, sum16}), 32'd0);
    chk("reset8_outputs", 32'({ir8, ov8, of8, c8, sum8}), 32'h800);

    start_op(0, 16'hFFFF, 16'h0001, 0, 0);
    exp_res = {1'b0, 1'b1, 16'h0000};
    finish_op(0, "add_ffff_1", 1);

    start_op(0, 16'h7FFF, 16'h0001, 0, 0);
    exp_res = {1'b1, 1'b0, 16'h8000};
    finish_op(0, "add_7fff_1", 0);

    start_op(0, 16'd5, 16'd7, 0, 1);
    exp_res = {1'b0, 1'b0, 16'hFFFE};
    finish_op(0, "sub_5_7", 0);

    start_op(0, 16'd7, 16'd5, 1, 1);
    exp_res = {1'b0, 1'b1, 16'h0001};
    finish_op(0, "sub_7_5_b", 0);

    // Backpressure: a new request waits through DONE and is taken one cycle after release.
    start_op(0, 16'h1234, 16'h1111, 0, 0);
    exp_res = {1'b0, 1'b0, 16'h2345};
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    drive(0, 1'b1, 16'hAAAA, 16'h0001, 0, 0);
    or16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", 32'({of16, c16, sum16}), 32'(exp_res));
      chk("bp_hold_valid", 32'(ov16), 32'd1);
      chk("bp_hold_in_ready", 32'(ir16), 32'd0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("bp_release_valid", 32'(ov16), 32'd0);
    chk("bp_release_ready", 32'(ir16), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_accepted", 32'(ir16), 32'd0);
    iv16 = 1'b0;
    exp_res = {1'b0, 1'b0, 16'hAAAB};
    finish_op(0, "bp_next", 0);

    // Reset two cycles into CALC drops the op.
    start_op(0, 16'h1234, 16'h4321, 0, 0);
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(ov16), 32'd0);
    chk("midrst_in_ready", 32'(ir16), 32'd1);
    chk("midrst_outputs", 32'({of16, c16, sum16}), 32'd0);
    start_op(0, 16'd3, 16'd4, 0, 0);
    exp_res = {1'b0, 1'b0, 16'd7};
    finish_op(0, "after_rst_add", 0);

    for (int i = 0; i < 1000; i++) begin
      start_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      finish_op(0, "rnd16", $urandom_range(0, 2));
    end

    start_op(1, 16'h00FF, 16'h0001, 0, 0);
    exp_res = {1'b0, 1'b1, 16'h0000};
    finish_op(1, "add8_ff_1", 1);

    for (int i = 0; i < 1000; i++) begin
      start_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      finish_op(1, "rnd8", $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
